fetch_unit: RTL

Instruction fetch front-end placed directly upstream of the single-cycle CPU core. It walks a word-addressed program counter (increment by 1), issues one read at a time to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small prefetch queue. The queue drains to the core over valid/ready. A redirect input from the core's branch resolution (target = pc+1+sign-extended constant) flushes the queue and restarts fetch.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-addressed PC step; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus bundle: instruction-memory read port, redirect input and core-side stream.
interface fetch_if import fetch_pkg::*; ();

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_ack, mem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with synchronous flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the top gates the head with the empty flag.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: one outstanding memory read, prefetch queue,
// and redirect handling that lets a stale in-flight read complete before refetching.
module fetch_unit import fetch_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_pend_pc;

  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] w_addr_nxt;
  logic [XLEN-1:0] w_pend_nxt;

  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;
  logic            w_pop;
  logic            w_push;
  logic            w_redir;
  logic            w_req_ack;
  logic [CW:0]     w_cnt_push;
  logic [CW-1:0]   w_cnt_idle;

  assign w_redir   = bus.redirect_valid;
  assign w_pop     = !w_empty && bus.out_ready;
  assign w_req_ack = (r_state == ST_REQ) && bus.mem_ack;
  assign w_push    = w_req_ack && !w_redir && (!w_full || w_pop);
  assign w_wdata   = '{pc: r_addr, instr: bus.mem_rdata};

  // Occupancy after this cycle, with the in-flight request holding a reserved slot.
  assign w_cnt_push = {1'b0, w_count} + (CW+1)'(1) - (CW+1)'(w_pop);
  assign w_cnt_idle = w_count - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pend_nxt  = r_pend_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_redir) begin
          w_addr_nxt  = bus.redirect_pc;
          w_state_nxt = ST_REQ;
        end else if (w_cnt_idle < CW'(DEPTH)) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_redir) begin
          if (bus.mem_ack) begin
            w_addr_nxt = bus.redirect_pc;
          end else begin
            w_pend_nxt  = bus.redirect_pc;
            w_state_nxt = ST_DRAIN;
          end
        end else if (bus.mem_ack) begin
          w_addr_nxt = pc_inc(r_addr);
          if (!(w_cnt_push < (CW+1)'(DEPTH))) w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_redir) w_pend_nxt = bus.redirect_pc;
        // The stale read completes here; its data is dropped.
        if (bus.mem_ack) begin
          w_addr_nxt  = w_redir ? bus.redirect_pc : r_pend_pc;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= RESET_PC;
      r_pend_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redir),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.mem_req   = (r_state != ST_IDLE);
  assign bus.mem_addr  = r_addr;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_empty ? '0 : w_head.pc;
  assign bus.out_instr = w_empty ? '0 : w_head.instr;

endmodule
